// File: rtl/aes_pkg.sv
// Shared AES column-mix definitions: FSM states, column count,
// MixColumns coefficient rows and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } imc_state_t;

  localparam int NUM_COLS = 4;

  // First matrix row; row r is this row rotated right by r bytes.
  // Element [0] is the coefficient applied to the same row index.
  localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};
  localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};

  // Low byte of the field polynomial x^8+x^4+x^3+x+1.
  localparam logic [7:0] POLY_RED = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY_RED : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b only the needed xtime taps survive.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_column_unit.sv
// One-column (Inv)MixColumns multiplier, purely combinational.
// With INV_MIX_COLUMNS_SEQ_FWD_EN defined, enc=1 selects the forward matrix.
module inv_mix_column_unit
  import aes_pkg::*;
(
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
  input  logic        enc,
`endif
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [3:0][7:0] coef;
  logic [7:0]      acc;
  logic [1:0]      ci;

  // Matrix-vector product: out_r = XOR_k coef[(k-r) mod 4] * s_k.
  always_comb begin
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
    coef = enc ? FWD_COEF : INV_COEF;
`else
    coef = INV_COEF;
`endif
    col_out = 32'h0;
    acc     = 8'h00;
    ci      = 2'd0;
    for (int r = 0; r < NUM_COLS; r++) begin
      acc = 8'h00;
      for (int k = 0; k < NUM_COLS; k++) begin
        ci  = 2'(k - r);
        acc = acc ^ gf_mul(col_in[8*k +: 8], coef[ci]);
      end
      col_out[8*r +: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: captures a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result
// until the consumer takes it. in_last bypasses the transform.
// Optional macro INV_MIX_COLUMNS_SEQ_FWD_EN adds mode_enc (forward MixColumns).
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         in_last,
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
  input  logic         mode_enc,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  // STEP truncates to 0 when all four columns go at once; the counter then simply stays 0.
  localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GROUP = 2'(NUM_COLS - COLS_PER_CYCLE);

  imc_state_t   state_reg, state_next;
  logic [1:0]   col_cnt_reg;
  logic [127:0] work_reg;
  logic         last_group;
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
  logic         mode_reg;
`endif

  logic [31:0]  unit_out [COLS_PER_CYCLE];
  logic [1:0]   col_idx  [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
    assign col_idx[gi] = col_cnt_reg + 2'(gi);
    inv_mix_column_unit u_unit (
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
      .enc     (mode_reg),
`endif
      .col_in  (work_reg[32*col_idx[gi] +: 32]),
      .col_out (unit_out[gi])
    );
  end

  assign last_group = (col_cnt_reg == LAST_GROUP);
  assign data_out   = work_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = in_last ? HOLD : COMPUTE;
      end
      COMPUTE: begin
        if (last_group) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working register: capture in IDLE, rewrite one column group per COMPUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg    <= 128'h0;
      col_cnt_reg <= 2'd0;
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
      mode_reg    <= 1'b0;
`endif
    end else if (state_reg == IDLE) begin
      if (in_valid) begin
        work_reg    <= data_in;
        col_cnt_reg <= 2'd0;
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
        mode_reg    <= mode_enc;
`endif
      end
    end else if (state_reg == COMPUTE) begin
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
        work_reg[32*col_idx[i] +: 32] <= unit_out[i];
      end
      col_cnt_reg <= col_cnt_reg + STEP;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// share data_in/in_last/rst; each has its own handshake. Results are checked
// against a field-arithmetic reference model and known AES vectors.
module tb_inv_mix_columns_seq;

  localparam logic [7:0] INV_M [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                          '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                          '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                          '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
  localparam logic [7:0] FWD_M [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                          '{8'h01, 8'h02, 8'h03, 8'h01},
                                          '{8'h01, 8'h01, 8'h02, 8'h03},
                                          '{8'h03, 8'h01, 8'h01, 8'h02}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_in = '0;
  logic         in_last = 1'b0;
  logic         mode_enc = 1'b0;
  logic [2:0]   in_valid_v = '0;
  logic [2:0]   out_ready_v = '0;
  logic [2:0]   in_ready_v, out_valid_v, busy_v;
  logic [127:0] data_out_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .data_in   (data_in),
      .in_last   (in_last),
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
      .mode_enc  (mode_enc),
`endif
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .data_out  (data_out_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input logic last, input logic enc);
    logic [127:0] r;
    logic [7:0]   acc;
    if (last) return din;
    r = din;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(enc ? FWD_M[row][k] : INV_M[row][k], din[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // One transfer through DUT d; hold_cycles>0 stalls the consumer in HOLD.
  task automatic run_txn(input int d, input logic [127:0] din, input logic last,
                         input logic enc, input int hold_cycles, output logic [127:0] got);
    int lat;
    int exp_lat;
    logic [127:0] exp;
    exp     = model(din, last, enc);
    exp_lat = last ? 1 : (4 / (1 << d)) + 1;
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready_v[d]), 128'd1);
    data_in        = din;
    in_last        = last;
    mode_enc       = enc;
    out_ready_v[d] = (hold_cycles == 0);
    in_valid_v[d]  = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      in_valid_v[d] = 1'b0;
      lat++;
      if (out_valid_v[d]) break;
    end
    check("latency", 128'(lat), 128'(exp_lat));
    got = data_out_v[d];
    check("data_out", got, exp);
    check("busy_hold", 128'(busy_v[d]), 128'd1);
    check("in_ready_hold", 128'(in_ready_v[d]), 128'd0);
    for (int h = 0; h < hold_cycles; h++) begin
      data_in       = {$urandom, $urandom, $urandom, $urandom};
      in_valid_v[d] = 1'b1;
      @(negedge clk);
      check("hold_valid", 128'(out_valid_v[d]), 128'd1);
      check("hold_data", data_out_v[d], exp);
      check("hold_in_ready", 128'(in_ready_v[d]), 128'd0);
    end
    in_valid_v[d]  = 1'b0;
    out_ready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after", {out_valid_v[d], busy_v[d], in_ready_v[d]}, 128'b001);
    out_ready_v[d] = 1'b0;
    $display("txn dut=%0d cpc=%0d last=%0b enc=%0b in=%h out=%h lat=%0d",
             d, 1 << d, last, enc, din, got, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] rnd;
    logic         rl, re;
    int           d, seen;

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_data", data_out_v[i], 128'h0);
      check("rst_ctrl", {out_valid_v[i], busy_v[i]}, 128'b00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready_v), 128'b111);

    // Known vector on each column rate
    for (int i = 0; i < 3; i++) begin
      run_txn(i, {4{32'hbca14d8e}}, 1'b0, 1'b0, 0, got);
      check("vec_bca1", got, {4{32'h455313db}});
    end
    run_txn(0, {32'h00000000, 32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f}, 1'b0, 1'b0, 0, got);
    check("vec_9d58", got, {32'h00000000, 32'h01010101, 32'hc6c6c6c6, 32'h5c220af2});
    run_txn(1, 128'h0123456789abcdeffedcba9876543210, 1'b1, 1'b0, 0, got);
    check("vec_last", got, 128'h0123456789abcdeffedcba9876543210);

    // Consumer stall for 10 cycles with ignored in_valid pulses
    run_txn(0, {4{32'hbca14d8e}}, 1'b0, 1'b0, 10, got);
    run_txn(2, 128'hdeadbeef00112233445566778899aabb, 1'b0, 1'b0, 3, got);

`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
    for (int i = 0; i < 3; i++) begin
      run_txn(i, {4{32'h455313db}}, 1'b0, 1'b1, 0, got);
      check("vec_fwd", got, {4{32'hbca14d8e}});
    end
`endif

    // Reset on second COMPUTE cycle discards the state
    @(negedge clk);
    data_in       = {4{32'h12345678}};
    in_last       = 1'b0;
    mode_enc      = 1'b0;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_data", data_out_v[0], 128'h0);
    check("midrst_ctrl", {out_valid_v, busy_v}, 128'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_v != 3'b000) seen++;
    end
    check("midrst_no_valid", 128'(seen), 128'd0);
    run_txn(0, {32'h00000000, 32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f}, 1'b0, 1'b0, 0, got);

    // Randomised traffic
    for (int n = 0; n < 30; n++) begin
      d   = int'($urandom_range(0, 2));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rl  = ($urandom_range(0, 3) == 0);
`ifdef INV_MIX_COLUMNS_SEQ_FWD_EN
      re  = 1'($urandom_range(0, 1));
`else
      re  = 1'b0;
`endif
      run_txn(d, rnd, rl, re, int'($urandom_range(0, 2)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per compute cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, data_in/in_last valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts a state this cycle.
REQ-006 SHALL have port data_in, input, 128, AES state: column c = bits [32c+31:32c]; row r of a column = bits [8r+7:8r].
REQ-007 SHALL have port in_last, input, 1, final decryption round: pass state through untransformed.
REQ-008 SHALL have port out_valid, output, 1, data_out valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts data_out.
REQ-010 SHALL have port data_out, output, 128, result, same column/row packing as data_in.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL compute per column, over GF(2^8) with polynomial 0x11B: out_r = XOR over k of M[r][k]*s_k, with M rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
REQ-013 SHALL use FSM states IDLE, COMPUTE, HOLD.
REQ-014 IDLE: in_ready=1; in_valid&&in_ready captures data_in into a 128-bit working register and clears the column counter.
REQ-015 On capture with in_last=0: IDLE->COMPUTE; with in_last=1: IDLE->HOLD with data unchanged.
REQ-016 COMPUTE: each cycle, replace COLS_PER_CYCLE columns starting at the counter index in place; counter += COLS_PER_CYCLE.
REQ-017 When the last column group is written: COMPUTE->HOLD; counter wraps to 0.
REQ-018 Latency, capture edge to first out_valid cycle: 4/COLS_PER_CYCLE + 1 cycles when in_last=0; 1 cycle when in_last=1.
REQ-019 HOLD: out_valid=1 and data_out stable until out_valid&&out_ready; then HOLD->IDLE.
REQ-020 in_ready SHALL be 0 in COMPUTE and HOLD; a single state is in flight at a time.
REQ-021 data_out SHALL be driven only from the working register, never combinationally from data_in.
REQ-022 in_valid while in_ready=0 SHALL be ignored, with no capture and no state change.

Reset
REQ-023 While rst=1: state=IDLE, counter=0, working register=0, out_valid=0, busy=0, data_out=0, in_ready=1 once rst deasserts.
REQ-024 rst asserted mid-COMPUTE or in HOLD SHALL discard the in-flight state, with no out_valid pulse.

Configuration
REQ-025 Macro INV_MIX_COLUMNS_SEQ_FWD_EN defined: extra input port mode_enc (1 bit), captured with data_in; mode_enc=1 selects forward MixColumns matrix rows {02,03,01,01} rotated; timing is identical.
REQ-026 Macro undefined: no mode_enc port; inverse transform only; no forward-multiply logic.

Structure
REQ-027 Shared package aes_pkg SHALL hold: the FSM state enum, NUM_COLS=4, the inverse and forward coefficient constants, and the reduction polynomial 0x1B.
REQ-028 SHALL instantiate COLS_PER_CYCLE copies of the combinational sub-module inv_mix_column_unit (32-bit in, 32-bit out, one column).

Verification
REQ-029 data_in=128'hbca14d8e repeated x4, in_last=0, out_ready=1 -> data_out=128'h455313db repeated x4, out_valid on cycle 5 after capture (COLS_PER_CYCLE=1).
REQ-030 Column 128'h...5c220af2 inverse of 128'h...9d58dc9f: data_in columns 9d58dc9f, c6c6c6c6, 01010101, 00000000 -> data_out columns 5c220af2, c6c6c6c6, 01010101, 00000000.
REQ-031 in_last=1, data_in=128'h0123456789abcdeffedcba9876543210 -> identical data_out, out_valid 1 cycle after capture.
REQ-032 out_ready=0 held 10 cycles in HOLD -> out_valid, data_out stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulse on cycle 2 of COMPUTE -> all outputs at reset values, no out_valid; the next capture produces correct data.
REQ-034 Repeat REQ-029 with COLS_PER_CYCLE=2 and 4 -> same data, latency 3 and 2 cycles; with FWD_EN, mode_enc=1 on 128'h455313db x4 -> 128'hbca14d8e x4.
